// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF sequencer.
//   state_t  : sequencer phases
//   SEL_W    : width of an oscillator select
//   NUM_RO   : number of ring oscillators in the array
//   pair_sel : maps (offset, stride, bit index) to the two oscillator selects
package ro_puf_pkg;

  localparam int unsigned NUM_RO = 16;
  localparam int unsigned SEL_W  = $clog2(NUM_RO);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;
  } sel_pair_t;

  // Oscillator pair for one response bit; all arithmetic wraps modulo NUM_RO.
  // A zero stride would compare an oscillator with itself, so it becomes 1.
  function automatic sel_pair_t pair_sel(input logic [SEL_W-1:0] offset,
                                         input logic [SEL_W-1:0] stride,
                                         input logic [SEL_W-1:0] idx);
    logic [SEL_W-1:0] s;
    sel_pair_t        p;
    s      = (stride == '0) ? SEL_W'(1) : stride;
    p.sel1 = offset + idx * s;
    p.sel2 = p.sel1 + s;
    return p;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clock   : destination clock
//   reset_n : asynchronous active-low reset, clears both flops
//   d       : asynchronous input
//   q       : synchronised output
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ro_puf_sequencer.sv
// Sequencer for the 16-oscillator RO PUF datapath. For each response bit it
// selects an oscillator pair, clears the counters, runs the oscillators for a
// fixed window, waits for the counters to settle and captures the comparator.
//   clock, reset_n      : system clock, asynchronous active-low reset
//   start, abort        : request a response / return to IDLE
//   stride, offset      : challenge (pair spacing and first select)
//   puf_bit             : comparator output, asynchronous to clock
//   cnt1, cnt2          : pair counter values, used for tie detection
//   ro_select1/2        : mux selects
//   ro_enable, ro_reset : oscillator/counter enable and clear
//   busy, done          : status; done pulses once per completed response
//   response, tie_mask  : captured bits and per-bit tie flags
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int unsigned N_BITS     = 16,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned WINDOW     = 4095,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  stride,
  input  logic [SEL_W-1:0]  offset,
  input  logic              puf_bit,
  input  logic [CNT_W-1:0]  cnt1,
  input  logic [CNT_W-1:0]  cnt2,
  output logic [SEL_W-1:0]  ro_select1,
  output logic [SEL_W-1:0]  ro_select2,
  output logic              ro_enable,
  output logic              ro_reset,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] response,
  output logic [N_BITS-1:0] tie_mask
);

  localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned T_MAX_A = (RST_CYC > WINDOW) ? RST_CYC : WINDOW;
  localparam int unsigned T_MAX   = (T_MAX_A > SETTLE_CYC) ? T_MAX_A : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] off_q;
  logic [SEL_W-1:0] str_q;
  logic             puf_s;
  sel_pair_t        start_pair;
  sel_pair_t        next_pair;
  logic             last_bit;
  logic             tmr_last;

  sync_2ff u_sync_puf (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (puf_bit),
    .q       (puf_s)
  );

  // Pair for bit 0 comes from the live challenge inputs (registered on the
  // same edge that latches them); later pairs come from the latched copy.
  always_comb begin
    start_pair = pair_sel(offset, stride, '0);
    next_pair  = pair_sel(off_q, str_q, SEL_W'(idx + IDX_W'(1)));
    last_bit   = (idx == IDX_W'(N_BITS - 1));
    tmr_last   = (tmr == TMR_W'(1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tmr        <= '0;
      idx        <= '0;
      off_q      <= '0;
      str_q      <= '0;
      ro_select1 <= '0;
      ro_select2 <= '0;
      ro_enable  <= 1'b0;
      ro_reset   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      response   <= '0;
      tie_mask   <= '0;
    end else if (abort && (state != IDLE)) begin
      state      <= IDLE;
      ro_select1 <= '0;
      ro_select2 <= '0;
      ro_enable  <= 1'b0;
      ro_reset   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            off_q      <= offset;
            str_q      <= stride;
            idx        <= '0;
            response   <= '0;
            tie_mask   <= '0;
            ro_select1 <= start_pair.sel1;
            ro_select2 <= start_pair.sel2;
            ro_reset   <= 1'b1;
            busy       <= 1'b1;
            tmr        <= TMR_W'(RST_CYC);
            state      <= CLEAR;
          end
        end

        CLEAR: begin
          if (tmr_last) begin
            ro_reset  <= 1'b0;
            ro_enable <= 1'b1;
            tmr       <= TMR_W'(WINDOW);
            state     <= RUN;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        RUN: begin
          if (tmr_last) begin
            ro_enable <= 1'b0;
            tmr       <= TMR_W'(SETTLE_CYC);
            state     <= SETTLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        SETTLE: begin
          if (tmr_last) begin
            state <= CAPTURE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        CAPTURE: begin
          response[idx] <= puf_s;
          tie_mask[idx] <= (cnt1 == cnt2);
          if (last_bit) begin
            ro_select1 <= '0;
            ro_select2 <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx        <= idx + IDX_W'(1);
            ro_select1 <= next_pair.sel1;
            ro_select2 <= next_pair.sel2;
            ro_reset   <= 1'b1;
            tmr        <= TMR_W'(RST_CYC);
            state      <= CLEAR;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer with a short configuration
// (4 bits, 2 clear, 8 run, 4 settle: 15 cycles per bit).
module tb_ro_puf_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  stride;
  logic [3:0]  offset;
  logic        puf_bit;
  logic [11:0] cnt1;
  logic [11:0] cnt2;
  logic [3:0]  ro_select1;
  logic [3:0]  ro_select2;
  logic        ro_enable;
  logic        ro_reset;
  logic        busy;
  logic        done;
  logic [3:0]  response;
  logic [3:0]  tie_mask;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0;

  ro_puf_sequencer #(
    .N_BITS     (4),
    .CNT_W      (12),
    .RST_CYC    (2),
    .WINDOW     (8),
    .SETTLE_CYC (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .stride     (stride),
    .offset     (offset),
    .puf_bit    (puf_bit),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .ro_select1 (ro_select1),
    .ro_select2 (ro_select2),
    .ro_enable  (ro_enable),
    .ro_reset   (ro_reset),
    .busy       (busy),
    .done       (done),
    .response   (response),
    .tie_mask   (tie_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Start pulse; returns at the negedge of the first CLEAR cycle.
  task automatic do_start(input logic [3:0] off, input logic [3:0] str);
    offset = off;
    stride = str;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  // Checks one bit period cycle by cycle, starting at its first CLEAR cycle.
  // abort_at >= 0 raises abort at that cycle and returns one cycle later.
  // poke re-pulses start and scrambles the challenge during the bit.
  task automatic run_bit(input string tag, input logic [3:0] s1, input logic [3:0] s2,
                         input logic pb, input logic tie, input int abort_at, input bit poke);
    logic [11:0] exp;
    puf_bit = pb;
    cnt1    = 12'd5;
    cnt2    = tie ? 12'd5 : 12'd9;
    for (int c = 0; c < 15; c++) begin
      exp = {(c < 2), (c >= 2 && c < 10), 1'b1, 1'b0, s1, s2};
      chk(tag, 64'({ro_reset, ro_enable, busy, done, ro_select1, ro_select2}), 64'(exp));
      if (poke && c == 5) begin
        start  = 1'b1;
        offset = 4'd3;
        stride = 4'd5;
      end
      if (poke && c == 6) start = 1'b0;
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic check_done(input string tag, input logic [3:0] rsp, input logic [3:0] tie);
    chk({tag, "_done"}, 64'({ro_reset, ro_enable, busy, done}), 64'(4'b0001));
    chk({tag, "_latency"}, 64'(cyc - t0), 64'(60));
    chk({tag, "_resp"}, 64'(response), 64'(rsp));
    chk({tag, "_tie"}, 64'(tie_mask), 64'(tie));
    @(negedge clock);
    chk({tag, "_idle"}, 64'({ro_reset, ro_enable, busy, done, ro_select1, ro_select2}), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    stride  = 4'd0;
    offset  = 4'd0;
    puf_bit = 1'b0;
    cnt1    = 12'd0;
    cnt2    = 12'd0;
    tick(2);
    chk("reset_ctl", 64'({ro_reset, ro_enable, busy, done, ro_select1, ro_select2}), 64'(0));
    chk("reset_res", 64'({response, tie_mask}), 64'(0));
    reset_n = 1'b1;
    tick(2);

    // Run 1: offset 14, stride 3, bits 1,0,1,1, tie on bit 2.
    do_start(4'd14, 4'd3);
    t0 = cyc;
    run_bit("r1b0", 4'd14, 4'd1,  1'b1, 1'b0, -1, 1'b0);
    run_bit("r1b1", 4'd1,  4'd4,  1'b0, 1'b0, -1, 1'b0);
    run_bit("r1b2", 4'd4,  4'd7,  1'b1, 1'b1, -1, 1'b0);
    run_bit("r1b3", 4'd7,  4'd10, 1'b1, 1'b0, -1, 1'b0);
    check_done("r1", 4'b1101, 4'b0100);
    tick(3);
    chk("r1_hold", 64'({response, tie_mask}), 64'({4'b1101, 4'b0100}));

    // Run 2: stride 0 acts as 1; start re-pulsed and challenge changed mid-run.
    do_start(4'd15, 4'd0);
    t0 = cyc;
    run_bit("r2b0", 4'd15, 4'd0, 1'b0, 1'b0, -1, 1'b0);
    run_bit("r2b1", 4'd0,  4'd1, 1'b1, 1'b0, -1, 1'b1);
    run_bit("r2b2", 4'd1,  4'd2, 1'b0, 1'b0, -1, 1'b0);
    run_bit("r2b3", 4'd2,  4'd3, 1'b0, 1'b0, -1, 1'b0);
    check_done("r2", 4'b0010, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      chk("r2_no_second_done", 64'({busy, done}), 64'(0));
      @(negedge clock);
    end

    // Run 3: abort during SETTLE of bit 2.
    do_start(4'd2, 4'd1);
    run_bit("r3b0", 4'd2, 4'd3, 1'b1, 1'b1, -1, 1'b0);
    run_bit("r3b1", 4'd3, 4'd4, 1'b1, 1'b0, -1, 1'b0);
    run_bit("r3b2", 4'd4, 4'd5, 1'b0, 1'b0, 11, 1'b0);
    chk("abort_idle", 64'({ro_reset, ro_enable, busy, done, ro_select1, ro_select2}), 64'(0));
    chk("abort_partial", 64'({response, tie_mask}), 64'({4'b0011, 4'b0001}));
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_done", 64'({busy, done}), 64'(0));
      @(negedge clock);
    end

    // start together with abort in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'({ro_reset, busy}), 64'(0));
    tick(2);

    // Run 4: new start clears results; async reset mid-RUN.
    do_start(4'd0, 4'd1);
    chk("restart_clear", 64'({response, tie_mask}), 64'(0));
    chk("restart_sel", 64'({ro_reset, busy, ro_select1, ro_select2}), 64'({2'b11, 4'd0, 4'd1}));
    tick(5);
    chk("mid_run", 64'({ro_reset, ro_enable, busy}), 64'(3'b011));
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_ctl", 64'({ro_reset, ro_enable, busy, done, ro_select1, ro_select2}), 64'(0));
    chk("async_reset_res", 64'({response, tie_mask}), 64'(0));
    tick(2);
    reset_n = 1'b1;
    tick(3);

    // Run 5: normal run after reset, stride 15 walks downward.
    do_start(4'd7, 4'd15);
    t0 = cyc;
    run_bit("r5b0", 4'd7, 4'd6, 1'b0, 1'b0, -1, 1'b0);
    run_bit("r5b1", 4'd6, 4'd5, 1'b0, 1'b0, -1, 1'b0);
    run_bit("r5b2", 4'd5, 4'd4, 1'b1, 1'b0, -1, 1'b0);
    run_bit("r5b3", 4'd4, 4'd3, 1'b0, 1'b1, -1, 1'b0);
    check_done("r5", 4'b0100, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
